// File: rtl/debug_latch_dumper_pkg.sv
// Shared definitions for the pipeline debug dumper: default latch widths,
// command codes, frame header and controller states.
package debug_latch_dumper_pkg;

   localparam int unsigned NB_IF_ID_DEF  = 64;
   localparam int unsigned NB_ID_EX_DEF  = 192;
   localparam int unsigned NB_EX_MEM_DEF = 128;
   localparam int unsigned NB_MEM_WB_DEF = 64;
   localparam int unsigned NB_BYTE_DEF   = 8;
   localparam int unsigned NB_COUNT_DEF  = 6;

   localparam logic [7:0] HEADER_DEF = 8'hA5;

   localparam logic [7:0] CMD_RUN   = 8'h63;  // 'c'
   localparam logic [7:0] CMD_PAUSE = 8'h70;  // 'p'
   localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
   localparam logic [7:0] CMD_DUMP  = 8'h64;  // 'd'

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_STEP,
      ST_CAPTURE,
      ST_SEND
   } state_t;

   function automatic int unsigned frame_bytes(input int unsigned nb_data,
                                               input int unsigned nb_byte);
      return nb_data / nb_byte;
   endfunction

endpackage

// File: rtl/debug_latch_dumper_dump_serializer.sv
// Snapshot register and valid/ready byte streamer: header byte first, then the
// snapshot MSB byte first.
module dump_serializer #(
   parameter int unsigned NB_DATA  = 448,
   parameter int unsigned NB_BYTE  = 8,
   parameter int unsigned NB_COUNT = 6,
   parameter logic [NB_BYTE-1:0] HEADER = 8'hA5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               load,
   input  logic [NB_DATA-1:0] data,
   input  logic               i_tx_ready,
   output logic [NB_BYTE-1:0] o_tx_byte,
   output logic               o_tx_valid,
   output logic               done
);

   localparam int unsigned N_BYTES = NB_DATA / NB_BYTE;
   localparam logic [NB_COUNT-1:0] LAST = NB_COUNT'(N_BYTES);

   logic [NB_DATA-1:0]  snapshot;
   logic [NB_COUNT-1:0] count;
   logic                xfer;

   assign xfer = o_tx_valid && i_tx_ready;
   assign done = xfer && (count == LAST);

   // count is the index of the byte currently on o_tx_byte; the snapshot
   // shifts left so the next outgoing byte always sits in the top slot.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         snapshot   <= '0;
         count      <= '0;
         o_tx_byte  <= '0;
         o_tx_valid <= 1'b0;
      end else if (load) begin
         snapshot   <= data;
         count      <= '0;
         o_tx_byte  <= HEADER;
         o_tx_valid <= 1'b1;
      end else if (xfer) begin
         if (count == LAST) begin
            o_tx_valid <= 1'b0;
            o_tx_byte  <= '0;
         end else begin
            o_tx_byte <= snapshot[NB_DATA-1 -: NB_BYTE];
            snapshot  <= snapshot << NB_BYTE;
            count     <= count + NB_COUNT'(1);
         end
      end
   end

endmodule

// File: rtl/debug_latch_dumper.sv
// Host debug unit: command FSM gating the pipeline clock enable, and latch
// snapshot dumps through the byte serializer.
module debug_latch_dumper
   import debug_latch_dumper_pkg::*;
#(
   parameter int unsigned NB_IF_ID  = NB_IF_ID_DEF,
   parameter int unsigned NB_ID_EX  = NB_ID_EX_DEF,
   parameter int unsigned NB_EX_MEM = NB_EX_MEM_DEF,
   parameter int unsigned NB_MEM_WB = NB_MEM_WB_DEF,
   parameter int unsigned NB_BYTE   = NB_BYTE_DEF,
   parameter logic [NB_BYTE-1:0] HEADER = HEADER_DEF,
   parameter int unsigned NB_COUNT  = NB_COUNT_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NB_IF_ID-1:0]  i_if_id,
   input  logic [NB_ID_EX-1:0]  i_id_ex,
   input  logic [NB_EX_MEM-1:0] i_ex_mem,
   input  logic [NB_MEM_WB-1:0] i_mem_wb,
   input  logic [NB_BYTE-1:0]   i_cmd_byte,
   input  logic                 i_cmd_valid,
   output logic [NB_BYTE-1:0]   o_tx_byte,
   output logic                 o_tx_valid,
   input  logic                 i_tx_ready,
   output logic                 o_mips_enable,
   output logic                 o_busy
);

   localparam int unsigned NB_TOTAL = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;

   state_t state;
   logic   load;
   logic   done;

   assign load = (state == ST_CAPTURE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= ST_IDLE;
         o_mips_enable <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_cmd_valid) begin
                  case (i_cmd_byte)
                     CMD_RUN: begin
                        state         <= ST_RUN;
                        o_mips_enable <= 1'b1;
                     end
                     CMD_STEP: begin
                        state         <= ST_STEP;
                        o_mips_enable <= 1'b1;
                        o_busy        <= 1'b1;
                     end
                     CMD_DUMP: begin
                        state  <= ST_CAPTURE;
                        o_busy <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            ST_RUN: begin
               if (i_cmd_valid && (i_cmd_byte == CMD_PAUSE)) begin
                  state         <= ST_IDLE;
                  o_mips_enable <= 1'b0;
               end
            end
            // One enabled cycle, then capture so the dump shows post-step latches.
            ST_STEP: begin
               state         <= ST_CAPTURE;
               o_mips_enable <= 1'b0;
            end
            ST_CAPTURE: state <= ST_SEND;
            ST_SEND: begin
               if (done) begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
               end
            end
            default: begin
               state         <= ST_IDLE;
               o_mips_enable <= 1'b0;
               o_busy        <= 1'b0;
            end
         endcase
      end
   end

   dump_serializer #(
      .NB_DATA  (NB_TOTAL),
      .NB_BYTE  (NB_BYTE),
      .NB_COUNT (NB_COUNT),
      .HEADER   (HEADER)
   ) u_dump_serializer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .load       (load),
      .data       ({i_if_id, i_id_ex, i_ex_mem, i_mem_wb}),
      .i_tx_ready (i_tx_ready),
      .o_tx_byte  (o_tx_byte),
      .o_tx_valid (o_tx_valid),
      .done       (done)
   );

   // Frame length is fixed by the latch widths; the counter must reach it.
   if (frame_bytes(NB_TOTAL, NB_BYTE) >= (1 << NB_COUNT)) begin : g_count_too_narrow
      count_width_too_small_for_frame u_bad ();
   end

endmodule
